// File: rtl/embcpumem_st_to_mem_writer.sv
// Byte-stream to memory write engine.
// Packs 8-bit Avalon-ST bytes little-endian into 32-bit words and issues one
// Avalon-MM write per word into a byte-enabled single-port RAM. The final
// word of a transfer carries a partial byteenable.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   start, base_addr,  control: start pulse (IDLE only), first word address,
//   length             byte count (0 completes immediately with no write)
//   snk_*              8-bit stream sink with backpressure and end-of-packet
//   mem_*              memory master write port (mem_clken tied high)
//   busy, done,        status: busy from start to end of DONE, done pulse,
//   short_pkt,         sticky early-eop flag, bytes accepted so far
//   byte_count
module embcpumem_st_to_mem_writer #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned LEN_W  = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [7:0]        snk_data,
  input  logic              snk_valid,
  output logic              snk_ready,
  input  logic              snk_endofpacket,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  output logic              busy,
  output logic              done,
  output logic              short_pkt,
  output logic [LEN_W:0]    byte_count
);

  localparam int unsigned CNT_W = LEN_W + 1;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t             state, state_n;
  logic [1:0]         lane_q, lane_n;
  logic [LEN_W-1:0]   len_q, len_n;
  logic               term_q, term_n;
  logic [ADDR_W-1:0]  ptr_n;
  logic [3:0]         be_n;
  logic [31:0]        data_n;
  logic [CNT_W-1:0]   cnt_n, cnt_inc;
  logic               short_n;
  logic               xfer, last_byte, early_eop;

  assign mem_clken = 1'b1;

  // Byte handshake and transfer-termination conditions for the current byte.
  assign xfer      = snk_valid & snk_ready;
  assign cnt_inc   = byte_count + CNT_W'(1);
  assign last_byte = (cnt_inc == {1'b0, len_q});
  assign early_eop = snk_endofpacket & (cnt_inc < {1'b0, len_q});

  // Next-state and next-register values.
  always_comb begin
    state_n = state;
    lane_n  = lane_q;
    len_n   = len_q;
    term_n  = term_q;
    ptr_n   = mem_address;
    be_n    = mem_byteenable;
    data_n  = mem_writedata;
    cnt_n   = byte_count;
    short_n = short_pkt;
    case (state)
      IDLE: begin
        if (start) begin
          ptr_n   = base_addr;
          len_n   = length;
          cnt_n   = '0;
          lane_n  = '0;
          be_n    = '0;
          data_n  = '0;
          short_n = 1'b0;
          term_n  = 1'b0;
          state_n = (length != '0) ? FILL : DONE;
        end
      end
      FILL: begin
        if (xfer) begin
          // Lanes are cleared before each word, so OR-ing places the byte.
          data_n = mem_writedata | (32'(snk_data) << {lane_q, 3'b000});
          be_n   = mem_byteenable | (4'b0001 << lane_q);
          cnt_n  = cnt_inc;
          lane_n = lane_q + 2'd1;
          if (early_eop) short_n = 1'b1;
          if (last_byte || snk_endofpacket) term_n = 1'b1;
          if ((lane_q == 2'd3) || last_byte || snk_endofpacket) state_n = WRITE;
        end
      end
      WRITE: begin
        ptr_n   = mem_address + ADDR_W'(1);
        lane_n  = '0;
        be_n    = '0;
        data_n  = '0;
        state_n = term_q ? DONE : FILL;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      lane_q         <= '0;
      len_q          <= '0;
      term_q         <= 1'b0;
      mem_address    <= '0;
      mem_byteenable <= '0;
      mem_writedata  <= '0;
      byte_count     <= '0;
      short_pkt      <= 1'b0;
      snk_ready      <= 1'b0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_n;
      lane_q         <= lane_n;
      len_q          <= len_n;
      term_q         <= term_n;
      mem_address    <= ptr_n;
      mem_byteenable <= be_n;
      mem_writedata  <= data_n;
      byte_count     <= cnt_n;
      short_pkt      <= short_n;
      snk_ready      <= (state_n == FILL);
      mem_chipselect <= (state_n == WRITE);
      mem_write      <= (state_n == WRITE);
      busy           <= (state_n != IDLE);
      done           <= (state_n == DONE);
    end
  end

endmodule
